// File: rtl/rr_mux_4x1_4bit.sv
// rtl/rr_mux_4x1_4bit.sv - registered round-robin 4:1 merge with source tag
// Define FIXED_PRIO_EN for fixed a>b>c>d priority instead of round-robin.
module rr_mux_4x1_4bit #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic [3:0]        in_valid,
    output logic [3:0]        in_ready,
    output logic [DATA_W-1:0] out,
    output logic [1:0]        out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [1:0]        grant;
    logic [DATA_W-1:0] grant_data;
    logic              load_en;

    // The output register may be refilled whenever it is empty or being drained.
    assign load_en  = !rst && (!out_valid || out_ready) && (|in_valid);
    assign in_ready = load_en ? (4'b0001 << grant) : 4'b0000;

`ifdef FIXED_PRIO_EN
    always_comb begin
        grant = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[k]) begin
                grant = 2'(k);
            end
        end
    end
`else
    logic [1:0] last_grant;
    logic [1:0] idx;
    logic       found;

    // Scan starts one past the previous winner so every requester is reached within four loads.
    always_comb begin
        grant = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 2'b11;
        end else if (load_en) begin
            last_grant <= grant;
        end
    end
`endif

    always_comb begin
        case (grant)
            2'd0:    grant_data = a;
            2'd1:    grant_data = b;
            2'd2:    grant_data = c;
            default: grant_data = d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_sel   <= 2'b00;
            out_valid <= 1'b0;
        end else if (load_en) begin
            out       <= grant_data;
            out_sel   <= grant;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
